// File: rtl/mem_copy_pkg.sv
// Shared definitions for the byte-wise memory copy engine: state encoding,
// default bus widths and a small state-decode helper.
package mem_copy_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

    function automatic logic state_is_busy(input copy_state_t st);
        return (st != IDLE);
    endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Byte-wise memory copy engine: alternates one read and one write per byte,
// ascending, with wrapping pointers and a single-cycle done pulse.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    copy_state_t           state_r;
    copy_state_t           state_next_s;
    logic [ADDR_WIDTH-1:0] src_ptr_r;
    logic [ADDR_WIDTH-1:0] src_ptr_next_s;
    logic [ADDR_WIDTH-1:0] dst_ptr_r;
    logic [ADDR_WIDTH-1:0] dst_ptr_next_s;
    logic [ADDR_WIDTH-1:0] count_r;
    logic [ADDR_WIDTH-1:0] count_next_s;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] data_next_s;

    logic                  busy_r;
    logic                  busy_next_s;
    logic                  done_r;
    logic                  done_next_s;
    logic [ADDR_WIDTH-1:0] mem_address_r;
    logic [ADDR_WIDTH-1:0] mem_address_next_s;
    logic                  mem_read_r;
    logic                  mem_read_next_s;
    logic                  mem_write_r;
    logic                  mem_write_next_s;
    logic [DATA_WIDTH-1:0] mem_write_data_r;
    logic [DATA_WIDTH-1:0] mem_write_data_next_s;

    // Next state and datapath: latch the request in IDLE, capture in READ, advance in WRITE.
    always_comb begin
        state_next_s   = state_r;
        src_ptr_next_s = src_ptr_r;
        dst_ptr_next_s = dst_ptr_r;
        count_next_s   = count_r;
        data_next_s    = data_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    src_ptr_next_s = src_addr;
                    dst_ptr_next_s = dst_addr;
                    count_next_s   = length;
                    if (length != ADDR_ZERO) begin
                        state_next_s = READ;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ: begin
                data_next_s  = mem_read_data;
                state_next_s = WRITE;
            end
            WRITE: begin
                // Pointers wrap naturally at the address width.
                src_ptr_next_s = src_ptr_r + ADDR_ONE;
                dst_ptr_next_s = dst_ptr_r + ADDR_ONE;
                count_next_s   = count_r - ADDR_ONE;
                if (count_r > ADDR_ONE) begin
                    state_next_s = READ;
                end else begin
                    state_next_s = DONE;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        busy_next_s           = state_is_busy(state_next_s);
        done_next_s           = (state_next_s == DONE);
        mem_address_next_s    = ADDR_ZERO;
        mem_read_next_s       = 1'b0;
        mem_write_next_s      = 1'b0;
        mem_write_data_next_s = DATA_ZERO;
        case (state_next_s)
            READ: begin
                mem_read_next_s    = 1'b1;
                mem_address_next_s = src_ptr_next_s;
            end
            WRITE: begin
                mem_write_next_s      = 1'b1;
                mem_address_next_s    = dst_ptr_next_s;
                mem_write_data_next_s = data_next_s;
            end
            IDLE, DONE: begin
                mem_read_next_s  = 1'b0;
                mem_write_next_s = 1'b0;
            end
            default: begin
                mem_read_next_s  = 1'b0;
                mem_write_next_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            src_ptr_r <= ADDR_ZERO;
            dst_ptr_r <= ADDR_ZERO;
            count_r   <= ADDR_ZERO;
            data_r    <= DATA_ZERO;
        end else begin
            state_r   <= state_next_s;
            src_ptr_r <= src_ptr_next_s;
            dst_ptr_r <= dst_ptr_next_s;
            count_r   <= count_next_s;
            data_r    <= data_next_s;
        end
    end

    // Output registers; reset drops any access on the following cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            mem_address_r    <= ADDR_ZERO;
            mem_read_r       <= 1'b0;
            mem_write_r      <= 1'b0;
            mem_write_data_r <= DATA_ZERO;
        end else begin
            busy_r           <= busy_next_s;
            done_r           <= done_next_s;
            mem_address_r    <= mem_address_next_s;
            mem_read_r       <= mem_read_next_s;
            mem_write_r      <= mem_write_next_s;
            mem_write_data_r <= mem_write_data_next_s;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign mem_address    = mem_address_r;
    assign mem_read       = mem_read_r;
    assign mem_write      = mem_write_r;
    assign mem_write_data = mem_write_data_r;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a byte memory model, a cycle-level
// behavioural model checked every cycle, and directed copy scenarios.
module tb_mem_copy_engine;
    import mem_copy_pkg::*;

    localparam int AW = DEFAULT_ADDR_WIDTH;
    localparam int DW = DEFAULT_DATA_WIDTH;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW-1:0] length;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;

    logic [DW-1:0] mem       [0:255] = '{default: 8'h00};
    logic [DW-1:0] model_mem [0:255] = '{default: 8'h00};

    logic          pl_en = 1'b0;
    logic [7:0]    pl_addr = 8'h00;
    logic [7:0]    pl_data = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    bit         m_active = 1'b0;
    int         m_cyc    = 0;
    int         m_len    = 0;
    logic [7:0] m_src    = 8'h00;
    logic [7:0] m_dst    = 8'h00;
    logic [7:0] m_byte   = 8'h00;

    always #5 clock = ~clock;

    mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Data memory: asynchronous read, write on the rising edge.
    assign mem_read_data = mem[mem_address];
    always @(posedge clock) begin
        if (mem_write) mem[mem_address] <= mem_write_data;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte i read at cycle 1+2i, written at 2+2i, done at 2*len+1.
    always @(negedge clock) begin : cmp
        logic       e_busy, e_done, e_rd, e_wr;
        logic [7:0] e_addr, e_wdata;
        int         last, i;
        if (pl_en) model_mem[pl_addr] = pl_data;
        if (check_en) begin
            e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
            e_addr = 8'h00; e_wdata = 8'h00;
            last = 2 * m_len + 1;
            if (m_active) begin
                e_busy = 1'b1;
                e_done = (m_cyc == last);
                if (m_cyc < last && (m_cyc % 2) == 1) begin
                    i      = (m_cyc - 1) / 2;
                    e_rd   = 1'b1;
                    e_addr = 8'(int'(m_src) + i);
                    m_byte = model_mem[e_addr];
                end
                if (m_cyc < last && (m_cyc % 2) == 0) begin
                    i       = (m_cyc - 2) / 2;
                    e_wr    = 1'b1;
                    e_addr  = 8'(int'(m_dst) + i);
                    e_wdata = m_byte;
                    model_mem[e_addr] = m_byte;
                end
            end
            check("busy",           32'(busy),           32'(e_busy));
            check("done",           32'(done),           32'(e_done));
            check("mem_read",       32'(mem_read),       32'(e_rd));
            check("mem_write",      32'(mem_write),      32'(e_wr));
            check("mem_address",    32'(mem_address),    32'(e_addr));
            check("mem_write_data", 32'(mem_write_data), 32'(e_wdata));
            if (!reset_n) begin
                m_active = 1'b0;
            end else if (m_active) begin
                if (m_cyc == last) m_active = 1'b0;
                else m_cyc++;
            end else if (start) begin
                m_active = 1'b1;
                m_cyc    = 1;
                m_src    = src_addr;
                m_dst    = dst_addr;
                m_len    = int'(length);
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] v);
        @(posedge clock); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    // Start a copy at cycle 0; optionally reset at abort_at or re-pulse start at restart_at.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int abort_at, input int restart_at,
                            output int done_cyc, output int busy_cnt, output int done_cnt,
                            output int rd_cnt, output int wr_cnt);
        int limit;
        limit = 2 * int'(l) + 4;
        done_cyc = -1; busy_cnt = 0; done_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        @(posedge clock); #1;
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
        for (int k = 0; k <= limit; k++) begin
            @(negedge clock);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (busy) busy_cnt++;
            if (mem_read) rd_cnt++;
            if (mem_write) wr_cnt++;
            @(posedge clock); #1;
            start   = (k + 1 == restart_at);
            reset_n = (k + 1 != abort_at);
            if (k + 1 == restart_at) begin
                src_addr = 8'hC0; dst_addr = 8'hC8; length = 8'h02;
            end
        end
        reset_n = 1'b1;
        start   = 1'b0;
    endtask

    int dc, bc, nc, rc, wc;

    initial begin
        reset_n = 1'b0; start = 1'b0;
        src_addr = 8'h00; dst_addr = 8'h00; length = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy",  32'(busy),        32'd0);
        check("reset_done",  32'(done),        32'd0);
        check("reset_rd",    32'(mem_read),    32'd0);
        check("reset_wr",    32'(mem_write),   32'd0);
        check("reset_addr",  32'(mem_address), 32'd0);
        reset_n  = 1'b1;
        check_en = 1'b1;

        // Basic 4-byte copy.
        preload(8'h00, 8'h08); preload(8'h01, 8'h11);
        preload(8'h02, 8'h22); preload(8'h03, 8'h33);
        run_copy(8'h00, 8'h10, 8'd4, -1, -1, dc, bc, nc, rc, wc);
        check("basic_done_cycle", 32'(dc), 32'd9);
        check("basic_busy_cycles", 32'(bc), 32'd9);
        check("basic_done_count", 32'(nc), 32'd1);
        check("basic_reads", 32'(rc), 32'd4);
        check("basic_writes", 32'(wc), 32'd4);
        check("basic_m10", 32'(mem[8'h10]), 32'h08);
        check("basic_m11", 32'(mem[8'h11]), 32'h11);
        check("basic_m12", 32'(mem[8'h12]), 32'h22);
        check("basic_m13", 32'(mem[8'h13]), 32'h33);

        // Second start and input changes while busy are ignored.
        run_copy(8'h00, 8'h60, 8'd4, -1, 3, dc, bc, nc, rc, wc);
        check("restart_done_cycle", 32'(dc), 32'd9);
        check("restart_done_count", 32'(nc), 32'd1);
        check("restart_m60", 32'(mem[8'h60]), 32'h08);
        check("restart_m63", 32'(mem[8'h63]), 32'h33);
        check("restart_mc8", 32'(mem[8'hC8]), 32'h00);

        // Zero length is a no-op with a done pulse at cycle 1.
        preload(8'h05, 8'h55); preload(8'h06, 8'h77);
        run_copy(8'h05, 8'h06, 8'd0, -1, -1, dc, bc, nc, rc, wc);
        check("len0_done_cycle", 32'(dc), 32'd1);
        check("len0_busy_cycles", 32'(bc), 32'd1);
        check("len0_reads", 32'(rc), 32'd0);
        check("len0_writes", 32'(wc), 32'd0);
        check("len0_m06", 32'(mem[8'h06]), 32'h77);

        // Source pointer wraps from 0xFF to 0x00.
        preload(8'hFE, 8'hAA); preload(8'hFF, 8'hBB); preload(8'h00, 8'hCC);
        run_copy(8'hFE, 8'h40, 8'd3, -1, -1, dc, bc, nc, rc, wc);
        check("wrap_done_cycle", 32'(dc), 32'd7);
        check("wrap_m40", 32'(mem[8'h40]), 32'hAA);
        check("wrap_m41", 32'(mem[8'h41]), 32'hBB);
        check("wrap_m42", 32'(mem[8'h42]), 32'hCC);

        // Reset in cycle 6 of an 8-byte copy: bytes 0-2 land, no done.
        for (int j = 0; j < 8; j++) preload(8'(8'h30 + j), 8'(8'hA0 + j));
        run_copy(8'h30, 8'h50, 8'd8, 6, -1, dc, bc, nc, rc, wc);
        check("abort_done_count", 32'(nc), 32'd0);
        check("abort_writes", 32'(wc), 32'd3);
        check("abort_m50", 32'(mem[8'h50]), 32'hA0);
        check("abort_m52", 32'(mem[8'h52]), 32'hA2);
        check("abort_m53", 32'(mem[8'h53]), 32'h00);

        // Overlapping forward copy replicates the first byte.
        preload(8'h20, 8'h5A);
        run_copy(8'h20, 8'h21, 8'd3, -1, -1, dc, bc, nc, rc, wc);
        check("overlap_m21", 32'(mem[8'h21]), 32'h5A);
        check("overlap_m22", 32'(mem[8'h22]), 32'h5A);
        check("overlap_m23", 32'(mem[8'h23]), 32'h5A);

        // Maximum length.
        run_copy(8'h00, 8'h80, 8'd255, -1, -1, dc, bc, nc, rc, wc);
        check("len255_done_cycle", 32'(dc), 32'd511);
        check("len255_writes", 32'(wc), 32'd255);
        check("len255_done_count", 32'(nc), 32'd1);

        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, data memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data memory word width.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, copy request, sampled only in IDLE.
REQ-006 SHALL have port src_addr, input, ADDR_WIDTH, first source address.
REQ-007 SHALL have port dst_addr, input, ADDR_WIDTH, first destination address.
REQ-008 SHALL have port length, input, ADDR_WIDTH, byte count; 0 = no-op.
REQ-009 SHALL have port busy, output, 1, high in every non-IDLE state.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port mem_address, output, ADDR_WIDTH, to Data_Memory address.
REQ-012 SHALL have port mem_read, output, 1, to Data_Memory mem_read.
REQ-013 SHALL have port mem_write, output, 1, to Data_Memory mem_write.
REQ-014 SHALL have port mem_write_data, output, DATA_WIDTH, to Data_Memory write_data.
REQ-015 SHALL have port mem_read_data, input, DATA_WIDTH, from Data_Memory read_data; valid in the same cycle mem_read and mem_address are driven.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-017 IDLE: on start=1 SHALL latch src_addr, dst_addr, length into internal registers and go to READ if length!=0, else DONE.
REQ-018 READ: SHALL drive mem_read=1, mem_write=0, mem_address=current source pointer, capture mem_read_data into a data register at the cycle end, go to WRITE.
REQ-019 WRITE: SHALL drive mem_write=1, mem_read=0, mem_address=current destination pointer, mem_write_data=captured byte; at cycle end increment both pointers, decrement remaining count, go to READ if remaining>1 else DONE.
REQ-020 DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-021 mem_read and mem_write SHALL never be high simultaneously; both 0 in IDLE and DONE; mem_address and mem_write_data SHALL be 0 outside READ/WRITE respectively.
REQ-022 Latency: with start sampled at cycle 0, byte i SHALL be read at cycle 1+2i, written at cycle 2+2i, done high at cycle 2*length+1 (cycle 1 for length 0).
REQ-023 Pointers SHALL wrap modulo 2^ADDR_WIDTH (0xFF+1 -> 0x00) with no error indication.
REQ-024 Copy SHALL be strictly ascending, byte-by-byte; overlapping ranges with dst>src SHALL replicate the source pattern (defined behaviour, no detection).
REQ-025 start while busy SHALL be ignored; input port changes while busy SHALL have no effect.
REQ-026 length=255 SHALL copy 255 bytes; the remaining count SHALL be ADDR_WIDTH bits, unsigned.

Reset
REQ-027 reset_n=0 at a rising edge SHALL force IDLE and clear busy, done, mem_read, mem_write, mem_address, mem_write_data, pointers, count, data register to 0.
REQ-028 Reset mid-copy SHALL abort without a done pulse; a write in flight in that cycle SHALL still be presented to memory, and no write SHALL be issued after reset.

Structure
REQ-029 State encodings (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3) and default widths SHALL live in shared package mem_copy_pkg, shared with the bench.
REQ-030 SHALL be a single module with no sub-module; outputs decoded from registered state.

Verification
REQ-031 Bench SHALL instantiate mem_copy_engine driving Data_Memory and cover:
- Preload mem[0x00..0x03]=08,11,22,33; src=0x00, dst=0x10, len=4 -> mem[0x10..0x13]=08,11,22,33, done at cycle 9, busy cycles 1-9.
- len=0, src=0x05, dst=0x06 -> done at cycle 1, no mem_read/mem_write pulses, memory unchanged.
- src=0xFE, dst=0x40, len=3, mem[0xFE,0xFF,0x00]=AA,BB,CC -> mem[0x40..0x42]=AA,BB,CC (source wrap).
- Start copy len=8, drop reset_n at cycle 6 -> all outputs 0 next cycle, no done, only bytes 0-2 written.
- Second start pulse at cycle 3 during len=4 copy -> ignored, exactly one done at cycle 9.
- Overlap src=0x20, dst=0x21, len=3, mem[0x20]=5A -> mem[0x21..0x23]=5A.
